// File: rtl/fft_frame_packer.sv
// Packs a multi-channel sample stream into FFT_LEN-sample Avalon-ST frames with sop/eop,
// buffering through a small FIFO and honouring sink backpressure.
module fft_frame_packer #(
  parameter int IN_W       = 14,
  parameter int OUT_W      = 16,
  parameter int CHANNELS   = 2,
  parameter int FFT_LEN    = 1024,
  parameter int FIFO_DEPTH = 16,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     chan_mode,
  input  logic [CW-1:0]            chan_sel,
  input  logic                     iq_mode,
  input  logic [CHANNELS*IN_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     sink_ready,
  output logic [OUT_W-1:0]         sink_real,
  output logic [OUT_W-1:0]         sink_imag,
  output logic                     sink_valid,
  output logic                     sink_sop,
  output logic                     sink_eop,
  output logic [CW-1:0]            frame_chan,
  output logic [15:0]              frame_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     dbg_state
);
  // Handshake: a sample transfers on a rising clk edge where sink_valid && sink_ready;
  // while sink_valid is high and sink_ready low, every sink_* output holds its value.

  localparam int DW = CHANNELS * IN_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FFT_LEN);
  localparam int SH = OUT_W - IN_W;
  localparam logic [CW:0] NCH_REAL = (CW+1)'(CHANNELS);
  localparam logic [CW:0] NCH_IQ   = (CW+1)'((CHANNELS >= 2) ? CHANNELS / 2 : 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            r_state, w_next_state;
  logic [DW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_frame_chan, r_rr;
  logic              r_iq;
  logic [OUT_W-1:0]  r_real, r_imag;
  logic              r_valid, r_sop, r_eop;
  logic [15:0]       r_frame_count;
  logic              r_overflow;

  logic              w_empty, w_full, w_push, w_pop, w_drop, w_load;
  logic              w_frame_start, w_last, w_eop_hs, w_out_free;
  logic [DW-1:0]     w_head;
  logic [CW:0]       w_nch, w_rr_inc, w_real_sel, w_imag_sel;
  logic [CW-1:0]     w_req_chan, w_new_chan, w_rr_next, w_chan;
  logic              w_iq;
  logic [IN_W-1:0]   w_real_raw, w_imag_raw;
  logic signed [OUT_W-1:0] w_real_ext, w_imag_ext;
  logic [OUT_W-1:0]  w_real_s, w_imag_s;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_head        = r_mem[r_rd_ptr];
  assign w_frame_start = (r_idx == '0);
  assign w_last        = (r_idx == IW'(FFT_LEN - 1));
  assign w_out_free    = !r_valid || sink_ready;
  assign w_eop_hs      = r_valid && sink_ready && r_eop;

  // A new frame may only begin while enabled; a frame in progress always completes.
  assign w_load = !w_empty && w_out_free &&
                  (w_frame_start ? enable : (r_state == S_STREAM));
  assign w_pop  = w_load;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  // Channel choice is resolved only when the sop sample loads.
  assign w_nch      = iq_mode ? NCH_IQ : NCH_REAL;
  assign w_req_chan = chan_mode ? r_rr : chan_sel;
  assign w_new_chan = ({1'b0, w_req_chan} < w_nch) ? w_req_chan : '0;
  assign w_rr_inc   = {1'b0, w_new_chan} + 1'b1;
  assign w_rr_next  = (w_rr_inc >= w_nch) ? '0 : w_rr_inc[CW-1:0];
  assign w_chan     = w_frame_start ? w_new_chan : r_frame_chan;
  assign w_iq       = w_frame_start ? iq_mode : r_iq;
  assign w_real_sel = w_iq ? {w_chan, 1'b0} : {1'b0, w_chan};
  assign w_imag_sel = {w_chan, 1'b1};

  always_comb begin
    w_real_raw = '0;
    w_imag_raw = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_real_sel == (CW+1)'(k)) w_real_raw = w_head[k*IN_W +: IN_W];
      if (w_imag_sel == (CW+1)'(k)) w_imag_raw = w_head[k*IN_W +: IN_W];
    end
  end

  assign w_real_ext = OUT_W'($signed(w_real_raw));
  assign w_imag_ext = OUT_W'($signed(w_imag_raw));
  assign w_real_s   = w_real_ext <<< SH;
  assign w_imag_s   = w_iq ? (w_imag_ext <<< SH) : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_real  <= '0;
      r_imag  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_real  <= w_real_s;
      r_imag  <= w_imag_s;
      r_valid <= 1'b1;
      r_sop   <= w_frame_start;
      r_eop   <= w_last;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end else if (sink_ready) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_chan  <= '0;
      r_rr          <= '0;
      r_iq          <= 1'b0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_load && w_frame_start) begin
        r_frame_chan <= w_new_chan;
        r_iq         <= iq_mode;
        if (chan_mode) r_rr <= w_rr_next;
      end
      if (w_eop_hs) r_frame_count <= r_frame_count + 1'b1;
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // STREAM with index 0 means the last frame's eop is loaded or already sent.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_load) w_next_state = S_STREAM;
      S_STREAM: if (w_frame_start && !enable && w_out_free) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign sink_real   = r_real;
  assign sink_imag   = r_imag;
  assign sink_valid  = r_valid;
  assign sink_sop    = r_sop;
  assign sink_eop    = r_eop;
  assign frame_chan  = r_frame_chan;
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed and randomized checks of fft_frame_packer (FFT_LEN=8, FIFO_DEPTH=4, 2 channels)
// against a frame-level reference model with an expected-sample queue.
module tb_fft_frame_packer;
  localparam int IN_W = 14, OUT_W = 16, CH = 2, LEN = 8, DEPTH = 4;
  localparam int IW = 35;

  logic              clk = 1'b0;
  logic              reset, enable, chan_mode, iq_mode, in_valid, sink_ready, ovf_clr;
  logic [0:0]        chan_sel;
  logic [CH*IN_W-1:0] in_data;
  logic [OUT_W-1:0]  sink_real, sink_imag;
  logic              sink_valid, sink_sop, sink_eop, overflow, dbg_state;
  logic [0:0]        frame_chan;
  logic [15:0]       frame_count;

  fft_frame_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .FFT_LEN(LEN),
                     .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mode(chan_mode), .chan_sel(chan_sel),
    .iq_mode(iq_mode), .in_data(in_data), .in_valid(in_valid), .sink_ready(sink_ready),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_valid(sink_valid),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .frame_chan(frame_chan),
    .frame_count(frame_count), .overflow(overflow), .ovf_clr(ovf_clr), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  logic [IW-1:0] exp_q[$];
  int checks = 0, failures = 0;
  int m_idx, m_rr, m_fc, n_acc, n_hs;
  logic m_chan, m_iq;
  int ready_mode;  // 0 fixed, 1 random, 2 toggle
  logic prev_stall;
  logic [IW:0] prev_snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] chan_of(input logic [CH*IN_W-1:0] w, input int k);
    logic [CH*IN_W-1:0] t;
    t = w >> (k * IN_W);
    return t[IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] v);
    int s;
    s = int'($signed(v)) * (1 << (OUT_W - IN_W));
    return s[OUT_W-1:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_idx = 0; m_rr = 0; m_fc = 0; n_acc = 0; n_hs = 0;
    m_chan = 1'b0; m_iq = 1'b0; prev_stall = 1'b0;
  endtask

  // One accepted input sample -> one expected output sample, in order.
  task automatic model_push(input logic [CH*IN_W-1:0] w);
    int nch, req, c;
    logic [IN_W-1:0] re, im;
    if (m_idx == 0) begin
      nch = iq_mode ? CH / 2 : CH;
      req = chan_mode ? m_rr : int'(chan_sel);
      c = (req < nch) ? req : 0;
      if (chan_mode) m_rr = (c + 1) % nch;
      m_chan = c[0];
      m_iq = iq_mode;
    end
    re = m_iq ? chan_of(w, 2 * int'(m_chan)) : chan_of(w, int'(m_chan));
    im = m_iq ? chan_of(w, 2 * int'(m_chan) + 1) : '0;
    exp_q.push_back({(m_idx == 0), (m_idx == LEN - 1), m_chan, scale(re),
                     m_iq ? scale(im) : 16'h0000});
    m_idx = (m_idx + 1) % LEN;
    n_acc++;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [IW-1:0] obs, exp;
    if (ready_mode == 1) sink_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) sink_ready = ~sink_ready;
    obs = {sink_sop, sink_eop, frame_chan, sink_real, sink_imag};
    if (prev_stall) check("stall_hold", {sink_valid, obs}, prev_snap);
    if (sink_valid && sink_ready) begin
      n_hs++;
      if (exp_q.size() == 0) check("unexpected_sample", {1'b1, obs}, '0);
      else begin
        exp = exp_q.pop_front();
        check("sample", obs, exp);
        if (exp[IW-2]) m_fc++;
      end
    end
    prev_stall = sink_valid && !sink_ready;
    prev_snap = {sink_valid, obs};
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CH*IN_W-1:0] w);
    int budget;
    budget = 200;
    while ((n_acc - n_hs) >= DEPTH && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("push_timeout", 1, 0);
    in_valid = 1'b1;
    in_data = w;
    model_push(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 500;
    while (exp_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) step();
  endtask

  function automatic logic [CH*IN_W-1:0] rnd_word();
    return (CH*IN_W)'({$urandom, $urandom});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int hs0, nfr, budget;
    reset = 1'b1; enable = 1'b0; chan_mode = 1'b0; chan_sel = 1'b0; iq_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; sink_ready = 1'b0; ovf_clr = 1'b0; ready_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", sink_valid, 0);
    check("rst_data", {sink_real, sink_imag}, 0);
    check("rst_sop_eop", {sink_sop, sink_eop}, 0);
    check("rst_count", frame_count, 0);
    check("rst_ovf_chan", {overflow, frame_chan}, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;

    // ramp on ch0, sink always ready; includes two-cycle latency check
    enable = 1'b1; sink_ready = 1'b1;
    push({14'($urandom), 14'd0});
    check("latency_n1", sink_valid, 0);
    push({14'($urandom), 14'd1});
    check("latency_n2", sink_valid, 1);
    check("first_sop_data", {sink_sop, sink_real, sink_imag}, {1'b1, 32'h0});
    for (int i = 2; i < LEN; i++) push({14'($urandom), 14'(i)});
    drain();
    check("ramp_frame_count", frame_count, 1);

    // toggling backpressure
    ready_mode = 2;
    for (int i = 0; i < LEN; i++) push(rnd_word());
    drain();
    ready_mode = 0; sink_ready = 1'b1;
    check("toggle_frame_count", frame_count, m_fc);

    // round-robin channel over three frames
    chan_mode = 1'b1;
    for (int i = 0; i < 3 * LEN; i++) push(rnd_word());
    drain();
    chan_mode = 1'b0;
    check("rr_frame_count", frame_count, 3 + 2);

    // overflow: sink blocked, 7 inputs, only FIFO + output register survive
    sink_ready = 1'b0;
    hs0 = n_hs;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = rnd_word();
      if (i < DEPTH + 1) model_push(in_data);
      step();
      if (i == DEPTH) check("ovf_before_drop", overflow, 0);
      if (i == DEPTH + 1) check("ovf_after_drop", overflow, 1);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    in_valid = 1'b0;
    check("ovf_clr_vs_drop", overflow, 1);
    sink_ready = 1'b1;
    drain();
    check("ovf_delivered", n_hs - hs0, DEPTH + 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // finish partial frame, then drop enable at index 3 of the next frame
    for (int i = 0; i < LEN - (DEPTH + 1); i++) push(rnd_word());
    drain();
    for (int i = 0; i < 4; i++) push(rnd_word());
    drain();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(rnd_word());
    drain();
    check("no_truncate_count", frame_count, m_fc);
    check("no_truncate_count_abs", frame_count, 7);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = rnd_word();
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("idle_no_output", sink_valid, 0);
    check("idle_state", dbg_state, 0);

    // reset flushes IDLE backlog; IQ pair extremes
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    enable = 1'b1; iq_mode = 1'b1; chan_sel = 1'b1;
    push({14'd8191, 14'h2000});
    push(rnd_word());
    check("iq_extremes", {sink_sop, frame_chan, sink_real, sink_imag}, {2'b10, 32'h8000_7FFC});
    for (int i = 0; i < 4; i++) push(rnd_word());
    budget = 100;
    while (!(exp_q.size() == 1 && sink_valid) && budget > 0) begin
      step();
      budget--;
    end
    check("reach_index5", exp_q.size(), 1);
    sink_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("midframe_rst_outputs", {sink_valid, sink_sop, sink_eop, sink_real, sink_imag}, 0);
    check("midframe_rst_count", frame_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sink_ready = 1'b1;
    for (int i = 0; i < LEN; i++) push(rnd_word());
    drain();
    check("post_rst_frame_count", frame_count, 1);

    // randomized segments
    ready_mode = 1;
    for (int seg = 0; seg < 8; seg++) begin
      chan_mode = 1'($urandom_range(0, 1));
      chan_sel = 1'($urandom_range(0, 1));
      iq_mode = 1'($urandom_range(0, 1));
      nfr = $urandom_range(1, 3);
      for (int i = 0; i < nfr * LEN; i++) begin
        repeat ($urandom_range(0, 2)) step();
        push(rnd_word());
      end
      drain();
      check("rand_frame_count", frame_count, m_fc);
      check("rand_no_overflow", overflow, 0);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
